// File: rtl/alu_pkg.sv
// Opcode encodings and request record shared by the alu and its arbiter wrapper.
package alu_pkg;
  localparam int ALU_DW = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTI = 4'b0011;
  localparam logic [3:0] ALU_BNE  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_SLLI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_ADDI = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_BLT  = 4'b1101;
  localparam logic [3:0] ALU_SRLI = 4'b1110;
  localparam logic [3:0] ALU_BGE  = 4'b1111;

  typedef struct packed {
    logic [ALU_DW-1:0] srca;
    logic [ALU_DW-1:0] srcb;
    logic [3:0]        op;
  } alu_req_t;
endpackage

// File: rtl/alu.sv
// Combinational alu. Compares are unsigned; shifts use the full SrcB, so
// shift amounts >= DATA_WIDTH flush to zero (or to the sign for SRAI).
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    i_srca,
  input  logic [DATA_WIDTH-1:0]    i_srcb,
  input  logic [OPCODE_LENGTH-1:0] i_op,
  output logic [DATA_WIDTH-1:0]    o_result
);
  logic w_ltu;
  logic w_eq;

  assign w_ltu = i_srca < i_srcb;
  assign w_eq  = i_srca == i_srcb;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_AND:                    o_result = i_srca & i_srcb;
      ALU_XOR:                    o_result = i_srca ^ i_srcb;
      ALU_OR:                     o_result = i_srca | i_srcb;
      ALU_ADD, ALU_ADDI:          o_result = i_srca + i_srcb;
      ALU_SUB:                    o_result = i_srca - i_srcb;
      ALU_SLTI, ALU_SLT, ALU_BLT: o_result = DATA_WIDTH'(w_ltu);
      ALU_BGE:                    o_result = DATA_WIDTH'(!w_ltu);
      ALU_BNE:                    o_result = DATA_WIDTH'(!w_eq);
      ALU_EQ:                     o_result = DATA_WIDTH'(w_eq);
      ALU_SLLI:                   o_result = i_srca << i_srcb;
      ALU_SRLI:                   o_result = i_srca >> i_srcb;
      ALU_SRAI:                   o_result = $unsigned($signed(i_srca) >>> i_srcb);
      ALU_LUI:                    o_result = i_srcb;
      default:                    o_result = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req scanning from ptr upward with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);
  logic        w_found;
  int unsigned w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(ptr) + k) % NUM_REQ;
      if (en && !w_found && req[w_j]) begin
        gnt[w_j] = 1'b1;
        gnt_idx  = IDX_W'(w_j);
        w_found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// One alu shared round-robin by NUM_REQ requesters; result is registered and
// returned to its owner, with a saturating count of ungranted-request cycles.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2,
  parameter int STALL_W       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [STALL_W-1:0]               stall_count
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic                     r_res_valid;
  logic [IDX_W-1:0]         r_res_owner;
  logic [DATA_WIDTH-1:0]    r_res_data;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [STALL_W-1:0]       r_stall;

  logic                     w_slot_free;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [IDX_W-1:0]         w_gnt_idx;
  logic [DATA_WIDTH-1:0]    w_srca;
  logic [DATA_WIDTH-1:0]    w_srcb;
  logic [OPCODE_LENGTH-1:0] w_op;
  logic [DATA_WIDTH-1:0]    w_alu_y;
  logic                     w_stall_evt;

  // A pending result that its owner consumes this cycle frees the slot for a new accept.
  assign w_slot_free = !r_res_valid || rsp_ready[r_res_owner];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_slot_free && !reset),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;

  assign w_srca = req_srca[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_srcb = req_srcb[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_op   = req_op[int'(w_gnt_idx)*OPCODE_LENGTH +: OPCODE_LENGTH];

  alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
    .i_srca   (w_srca),
    .i_srcb   (w_srcb),
    .i_op     (w_op),
    .o_result (w_alu_y)
  );

  assign w_stall_evt = |(req_valid & ~req_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_owner <= '0;
      r_res_data  <= '0;
      r_rr_ptr    <= '0;
      r_stall     <= '0;
    end else begin
      if (|w_gnt) begin
        r_res_data  <= w_alu_y;
        r_res_owner <= w_gnt_idx;
        r_res_valid <= 1'b1;
        r_rr_ptr    <= (w_gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end else if (w_slot_free) begin
        r_res_valid <= 1'b0;
      end
      if (w_stall_evt && (r_stall != '1)) r_stall <= r_stall + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = r_res_valid && (r_res_owner == IDX_W'(i));
  end

  assign rsp_data    = r_res_data;
  assign stall_count = r_stall;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single op, round-robin, backpressure,
// reset mid-op, stall saturation (STALL_W=4 copy) and an opcode table sweep.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR-1:0]    req_ready4, rsp_valid4;
  logic [NR*DW-1:0] req_srca, req_srcb;
  logic [NR*OW-1:0] req_op;
  logic [DW-1:0]    rsp_data, rsp_data4;
  logic [15:0]      stall_count;
  logic [3:0]       stall_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR), .STALL_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .stall_count(stall_count)
  );

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR), .STALL_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
    .stall_count(stall_count4)
  );

  // Requester rule: an unaccepted request holds valid and payload until accepted (reset withdraws).
  logic [NR-1:0]    p_valid = '0, p_ready = '0;
  logic             p_reset = 1'b1;
  logic [NR*DW-1:0] p_a = '0, p_b = '0;
  logic [NR*OW-1:0] p_op = '0;
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (!p_reset && !reset && p_valid[i] && !p_ready[i])
        assert (req_valid[i] && req_srca[i*DW +: DW] == p_a[i*DW +: DW] &&
                req_srcb[i*DW +: DW] == p_b[i*DW +: DW] && req_op[i*OW +: OW] == p_op[i*OW +: OW])
          else $error("requester %0d changed an unaccepted request", i);
    end
    p_valid <= req_valid;
    p_ready <= req_ready;
    p_reset <= reset;
    p_a     <= req_srca;
    p_b     <= req_srcb;
    p_op    <= req_op;
  end

  typedef struct {
    string      nm;
    alu_req_t   req;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input string nm, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.nm = nm; v.req.op = op; v.req.srca = a; v.req.srcb = b; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*OW +: OW]   = op;
    req_srca[i*DW +: DW] = a;
    req_srcb[i*DW +: DW] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("and",   ALU_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00);
    vecs[1]  = mk("xor",   ALU_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F);
    vecs[2]  = mk("add",   ALU_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001);
    vecs[3]  = mk("slti",  ALU_SLTI, 32'h00000003, 32'hFFFFFFFF, 32'h00000001);
    vecs[4]  = mk("bne",   ALU_BNE,  32'h00000005, 32'h00000005, 32'h00000000);
    vecs[5]  = mk("or",    ALU_OR,   32'h000000F0, 32'h0000000F, 32'h000000FF);
    vecs[6]  = mk("slli",  ALU_SLLI, 32'h00000001, 32'h0000001F, 32'h80000000);
    vecs[7]  = mk("srai",  ALU_SRAI, 32'h80000000, 32'h00000004, 32'hF8000000);
    vecs[8]  = mk("eq",    ALU_EQ,   32'h00000007, 32'h00000007, 32'h00000001);
    vecs[9]  = mk("lui",   ALU_LUI,  32'h12345678, 32'hABCD0000, 32'hABCD0000);
    vecs[10] = mk("sub",   ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE);
    vecs[11] = mk("addi",  ALU_ADDI, 32'h0000000A, 32'h00000014, 32'h0000001E);
    vecs[12] = mk("slt",   ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000000);
    vecs[13] = mk("blt",   ALU_BLT,  32'h00000001, 32'h00000002, 32'h00000001);
    vecs[14] = mk("srli",  ALU_SRLI, 32'h80000000, 32'h0000001F, 32'h00000001);
    vecs[15] = mk("bge",   ALU_BGE,  32'h00000002, 32'h00000003, 32'h00000000);
    vecs[16] = mk("sll32", ALU_SLLI, 32'h00000001, 32'h00000020, 32'h00000000);
    vecs[17] = mk("srl256",ALU_SRLI, 32'hFFFFFFFF, 32'h00000100, 32'h00000000);

    // 1. reset held 3 cycles with both requesters valid
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(1, ALU_ADD, 32'd2, 32'd2);
    #1 chk("rst_ready", req_ready, 2'b00);
    repeat (3) tick();
    chk("rst_ready_late", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_stall", stall_count, 16'd0);
    reset = 1'b0; req_valid = 2'b00;

    // 2. single ADD on requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 2'b01; rsp_ready = 2'b01;
    #1 chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_data", rsp_data, 32'd12);
    tick();
    chk("single_drained", rsp_valid, 2'b00);
    chk("single_data_held", rsp_data, 32'd12);
    chk("single_stall", stall_count, 16'd0);

    // 3. round robin with both requesters continuously valid
    do_reset();
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_SLLI, 32'd1, 32'd4);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] e;
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk($sformatf("rr_ready_%0d", k), req_ready, e);
      chk($sformatf("rr_stall_%0d", k), stall_count, k);
      tick();
      chk($sformatf("rr_rsp_valid_%0d", k), rsp_valid, e);
      chk($sformatf("rr_rsp_data_%0d", k), rsp_data, (k % 2 == 0) ? 32'd7 : 32'd16);
    end

    // 4. backpressure on owner 0; rsp_ready of non-owner 1 must be ignored
    do_reset();
    set_req(0, ALU_SLT, 32'd3, 32'd9);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1 chk("bp_first_ready", req_ready, 2'b01);
    tick();
    set_req(0, ALU_ADD, 32'd2, 32'd2);
    rsp_ready = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), req_ready, 2'b00);
      chk($sformatf("bp_valid_%0d", k), rsp_valid, 2'b01);
      chk($sformatf("bp_data_%0d", k), rsp_data, 32'd1);
      tick();
    end
    chk("bp_stall", stall_count, 16'd4);
    rsp_ready = 2'b01;
    #1 chk("bp_drain_accept", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("bp_new_valid", rsp_valid, 2'b01);
    chk("bp_new_data", rsp_data, 32'd4);
    chk("bp_stall_after", stall_count, 16'd4);
    tick();
    chk("bp_final_valid", rsp_valid, 2'b00);

    // 5. reset while requester 1 result is pending
    do_reset();
    set_req(1, ALU_BGE, 32'd8, 32'd8);
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1 chk("rm_ready", req_ready, 2'b10);
    tick();
    chk("rm_valid", rsp_valid, 2'b10);
    chk("rm_data", rsp_data, 32'd1);
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    req_valid = 2'b11; reset = 1'b1;
    #1 chk("rm_ready_in_reset", req_ready, 2'b00);
    tick();
    reset = 1'b0;
    chk("rm_valid_cleared", rsp_valid, 2'b00);
    chk("rm_data_cleared", rsp_data, 32'd0);
    rsp_ready = 2'b11;
    #1 chk("rm_req0_first", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    chk("rm_rsp0_valid", rsp_valid, 2'b01);
    chk("rm_rsp0_data", rsp_data, 32'd2);
    #1 chk("rm_req1_next", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("rm_rsp1_valid", rsp_valid, 2'b10);
    chk("rm_rsp1_data", rsp_data, 32'd1);

    // opcode sweep on requester 0
    do_reset();
    rsp_ready = 2'b01;
    foreach (vecs[k]) begin
      set_req(0, vecs[k].req.op, vecs[k].req.srca, vecs[k].req.srcb);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      chk({"op_valid_", vecs[k].nm}, rsp_valid, 2'b01);
      chk({"op_", vecs[k].nm}, rsp_data, vecs[k].exp);
    end
    chk("op_sweep_stall", stall_count, 16'd0);

    // 6. stall saturation: slot held full, both requesters blocked 20 cycles
    do_reset();
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_SUB, 32'd5, 32'd1);
    req_valid = 2'b11; rsp_ready = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 13) chk("sat4_at14", stall_count4, 4'd14);
      if (k == 14) begin
        chk("sat4_at15", stall_count4, 4'd15);
        chk("sat16_at15", stall_count, 16'd15);
      end
    end
    chk("sat4_final", stall_count4, 4'd15);
    chk("sat16_final", stall_count, 16'd20);
    chk("sat_rsp_data", rsp_data, 32'd3);
    reset = 1'b1;
    tick();
    req_valid = 2'b00; reset = 1'b0;
    chk("sat_reset_stall", stall_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
